// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux-select arbiter.
package rr_mux_sel_arbiter_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_mux_sel_arbiter_if.sv
// Request/grant bundle between the channel side and the arbiter, plus FSM state for checkers.
interface rr_mux_sel_arbiter_if;
  import rr_mux_sel_arbiter_pkg::*;

  // Handshake: each channel holds req[n] while it wants the mux; the owner pulses done for
  // one cycle to hand back the grant. valid qualifies sel/grant and equals |grant.
  logic [N_CH-1:0]  req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  grant;
  logic             valid;
  state_t           state;

  modport master (output req, done, input sel, grant, valid, state);
  modport slave  (input req, done, output sel, grant, valid, state);
endinterface

// File: rtl/rr_mux_sel_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit scanning from ptr upward, mod 4.
module rr_pick
  import rr_mux_sel_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [SEL_W-1:0]  off;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_CH];
    off = '0;
    // Walk downward so the lowest set bit of the rotated vector wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    found = |rot;
    idx   = ptr + off;
  end
endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving a registered 2-bit select into a 4:1 mux, with bounded hold time.
module rr_mux_sel_arbiter
  import rr_mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_sel_arbiter_if.slave  bus
);
  localparam int HCNT_W = $clog2(MAX_HOLD);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic [N_CH-1:0]   owner_oh, others, pick_req;
  logic [SEL_W-1:0]  pick_ptr, pick_idx;
  logic              pick_found, at_limit, timeout, rel;

  // While granted, sel_q is the owner index.
  assign owner_oh = onehot(sel_q);
  assign others   = bus.req & ~owner_oh;
  assign at_limit = (hcnt_q == HCNT_W'(MAX_HOLD - 1));
  assign timeout  = (state_q == ST_GRANT) && at_limit && (|others);
  assign rel      = (state_q == ST_GRANT) &&
                    (bus.done || !(|(bus.req & owner_oh)) || timeout);

  // On release the search starts just past the owner, so the owner naturally ranks last.
  assign pick_ptr = (state_q == ST_GRANT) ? sel_q + SEL_W'(1) : ptr_q;
  assign pick_req = timeout ? others : bus.req;

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          grant_d = onehot(pick_idx);
          valid_d = 1'b1;
          hcnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          ptr_d = pick_ptr;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = onehot(pick_idx);
            valid_d = 1'b1;
            hcnt_d  = '0;
          end else begin
            // sel keeps its value so the downstream mux does not toggle.
            state_d = ST_IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            hcnt_d  = '0;
          end
        end else if (!at_limit) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
  assign bus.state = state_q;
endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Round-robin arbiter sitting directly upstream of the 4:1 conditional mux.
- Takes four channel request lines and produces the registered 2-bit select that drives the mux select input, plus a one-hot grant and a valid flag.
- Guarantees fair, glitch-free select changes and bounded hold time per channel.

Parameters:
- MAX_HOLD, default 8: max consecutive cycles one channel keeps the grant while another channel is requesting. Legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  4  per-channel request; bit n = channel n (mux data input n).
- done  input  1  current owner releases the grant this cycle.
- sel  output  2  registered select to the 4:1 mux (bit1 = upper stage, bit0 = first stage).
- grant  output  4  one-hot owner; 4'b0000 when no owner.
- valid  output  1  high while sel points at a granted channel.

Behaviour:
- Reset (async assert, sync deassert by design convention upstream):
  - sel=2'd0, grant=4'b0000, valid=0.
  - State IDLE, priority pointer ptr=0, hold counter hcnt=0.
  - Takes effect immediately, including mid-grant.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, the winner is the first set bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: GRANT, grant=onehot(winner), sel=winner, valid=1, hcnt=0.
  - If req==0: stay IDLE, valid=0, grant=0, sel holds its last value (no mux toggling).
- Latency: req sampled high in cycle k gives grant/valid high in cycle k+1.
- GRANT with owner o, release condition R is any of:
  - done==1
  - req[o]==0
  - hcnt==MAX_HOLD-1 and (req & ~onehot(o))!=0
- GRANT, no release: hcnt increments each cycle.
  - hcnt saturates at MAX_HOLD-1 while only o is requesting; the owner keeps the grant with no forced rotation.
- GRANT, release:
  - ptr = (o+1) mod 4 (wrap 3->0).
  - Winner is picked from the current req, scanning from the new ptr; o's own request, if still set, has lowest priority.
  - Winner found: next cycle grant=onehot(winner), sel=winner, valid=1, hcnt=0. Back-to-back, with no bubble.
  - No winner: next cycle IDLE, valid=0, grant=0, sel holds.
- Simultaneous done and timeout in the same cycle are treated as a single release.
- done while IDLE is ignored.
- sel, grant and valid are all registered; no combinational path from req or done to the outputs.
- Invariants:
  - grant is always zero or one-hot.
  - valid == |grant.
  - When valid=1, sel == index(grant).
- hcnt width is clog2(MAX_HOLD). Only values 0..MAX_HOLD-1 are used.

Decomposition:
- Shared package holds:
  - N_CH=4, SEL_W=2
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - the onehot(idx) function
- One combinational sub-module, rr_pick:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Rotates req by ptr, does a fixed-priority search, then rotates the index back.
- The arbiter instantiates rr_pick once.
- The arbiter masks the owner's bit on a hold-timeout release.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 → sel=0, grant=0000, valid=0 throughout. Release reset with req=0 → outputs stay reset values for 5 cycles.
- Single request: req=4'b0100 set in cycle k → cycle k+1: grant=0100, sel=2, valid=1. done pulse in cycle k+3 with req dropped → cycle k+4: valid=0, grant=0, sel stays 2. Next req=4'b1000 → grant=1000 (ptr was 3).
- Fairness: req=4'b1111 held, done pulsed every grant cycle → sel sequence 0,1,2,3,0,1 on consecutive cycles, valid continuously 1.
- Hold timeout (MAX_HOLD=8): req=4'b0011, done=0 → ch0 granted for exactly 8 cycles, then ch1 for 8 cycles, then ch0; no bubble cycles.
- Sole requester: req=4'b0001, done=0 for 20 cycles → grant=0001 for all 20 cycles, no rotation.
- Async reset mid-grant: assert rst_n=0 between clock edges while grant=0010 → outputs clear before the next edge. After release, with req=4'b0010 → re-grant ch1 one cycle later, starting from ptr=0.
